ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 4: word width; matches RAM dina/dinb/douta/doutb.
REQ-002 Parameter ADDR_W, default 2: RAM address width; depth DEPTH = 2**ADDR_W = 4.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset; synchronous, active-high.
REQ-005 Port in_valid, input, 1: upstream word offered.
REQ-006 Port in_ready, output, 1: controller accepts the word this cycle.
REQ-007 Port in_data, input, DATA_W: upstream word.
REQ-008 Port out_valid, output, 1: out_data holds a valid word.
REQ-009 Port out_ready, input, 1: downstream takes out_data this cycle.
REQ-010 Port out_data, output, DATA_W: registered output word.
REQ-011 Ports wea (output, 1), addra (output, ADDR_W), dina (output, DATA_W): RAM port A write side.
REQ-012 Ports web (output, 1), addrb (output, ADDR_W), dinb (output, DATA_W): RAM port B; web and dinb are tied to 0.
REQ-013 Port doutb, input, DATA_W: RAM port B read data, valid in the cycle after addrb is sampled.
REQ-014 Port level, output, ADDR_W+1: words stored in RAM, 0..DEPTH; excludes the in-flight read and the output register.

Function
REQ-015 Push: in_ready = !rst && level < DEPTH; push = in_valid && in_ready.
REQ-016 On push: wea=1, addra=wr_ptr, dina=in_data in the same cycle; wr_ptr increments at the edge, wrapping 3->0.
REQ-017 addrb always equals rd_ptr.
REQ-018 Read issue in cycle c: rd_issue = level>0 && !rd_pend && (!out_valid || out_ready); at the edge rd_ptr increments (wrap 3->0) and rd_pend sets.
REQ-019 In cycle c+1, with rd_pend=1: doutb is captured into out_data at the edge, out_valid sets, rd_pend clears; first word is visible at out_valid in cycle c+2.
REQ-020 Output handshake: word leaves when out_valid && out_ready; out_valid clears unless a pending load arrives at the same edge.
REQ-021 out_data and out_valid are held stable while out_valid && !out_ready.
REQ-022 level update: +1 on push only; -1 on rd_issue only; unchanged when both occur together.
REQ-023 Sustained throughput is one word per two cycles; write-to-first-output latency is 3 cycles (push at t, issue at t+1, out_valid at t+3).
REQ-024 Full (level=4): in_ready=0, wea=0; a read issued in the same cycle does not raise in_ready until the next cycle.
REQ-025 Empty (level=0): no read issued; addrb is still driven with rd_ptr.
REQ-026 Collision-free: wea && rd_issue never coincide with addra == addrb.
REQ-027 Data order is strict FIFO across pointer wrap.

Reset
REQ-028 When rst is high at an edge: wr_ptr=0, rd_ptr=0, level=0, rd_pend=0, out_valid=0, out_data=0.
REQ-029 During rst: in_ready=0 and wea=0.
REQ-030 Reset mid-operation discards stored words and any in-flight read; the doutb returned after reset is ignored.

Structure
REQ-031 Package ram_fifo_pkg holds DATA_W, ADDR_W, DEPTH and the level width constant.
REQ-032 The output stage (rd_pend, out register, load and handshake logic) is sub-module ram_fifo_outreg.
REQ-033 The controller contains no storage array; all words reside in the external dual-port RAM.

Verification
REQ-034 Reset, then push 0x1,0x2,0x3 on consecutive cycles with out_ready=1 -> out_data 0x1,0x2,0x3 in order; first out_valid 3 cycles after the first push.
REQ-035 out_ready=0, push 0xA,0xB,0xC,0xD,0xE -> 0xA is held in the output register, the RAM holds 0xB..0xE, level=4, in_ready=0; 0xE is not stalled; after release the output is 0xA..0xE.
REQ-036 Push/pop 10 words 0x0..0x9 continuously -> pointers wrap 3->0 twice, output order is preserved, and wea/addra never equal addrb on an issue cycle.
REQ-037 Back-pressure: toggle out_ready every cycle -> out_data is stable whenever out_valid && !out_ready; no loss or duplication.
REQ-038 Assert rst for 1 cycle while level=3 and a read is pending -> the next cycle has level=0 and out_valid=0, and later pushes 0x5,0x6 emerge as 0x5,0x6.
REQ-039 Simultaneous push and issue at level=2 -> level stays 2 and both RAM ports are active on distinct addresses.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared sizing constants for the external-RAM FIFO controller.
// The controller and its output stage take their parameter defaults from here.
package ram_fifo_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned LVL_W  = ADDR_W + 1;

endpackage

// File: rtl/ram_fifo_outreg.sv
// Output stage: tracks the one-cycle RAM read latency and owns the registered output word
// with its valid/ready handshake.
module ram_fifo_outreg #(
    parameter int unsigned DATA_W = ram_fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_issue_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              out_ready_i,
    output logic              can_issue_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic              rd_pend_q, rd_pend_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    always_comb begin
        // A read is only issued when nothing is pending, so pending lasts exactly one cycle.
        rd_pend_d   = rd_issue_i;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (rd_pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data_i;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        // The register is guaranteed free by the time the issued read lands.
        can_issue_o = !rd_pend_q && (!out_valid_q || out_ready_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM: port A writes pushed words, port B reads
// them back into a registered output stage.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = ram_fifo_pkg::DATA_W,
    parameter int unsigned ADDR_W = ram_fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dinb,
    input  logic [DATA_W-1:0] doutb,
    output logic [ADDR_W:0]   level
);

    localparam int unsigned     LvlW    = ADDR_W + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(1 << ADDR_W);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              push;
    logic              rd_issue;
    logic              can_issue;

    always_comb begin
        in_ready = !rst && (level_q < LvlFull);
        push     = in_valid && in_ready;
        rd_issue = !rst && (level_q != '0) && can_issue;

        // Pointers wrap naturally because the depth is a power of two.
        wr_ptr_d = push     ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_issue ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        unique case ({push, rd_issue})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign wea   = push;
    assign addra = wr_ptr_q;
    assign dina  = in_data;
    assign web   = 1'b0;
    assign addrb = rd_ptr_q;
    assign dinb  = '0;
    assign level = level_q;

    ram_fifo_outreg #(
        .DATA_W(DATA_W)
    ) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .rd_issue_i (rd_issue),
        .rd_data_i  (doutb),
        .out_ready_i(out_ready),
        .can_issue_o(can_issue),
        .out_valid_o(out_valid),
        .out_data_o (out_data)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural dual-port RAM and a queue-based scoreboard.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       wea;
    logic [1:0] addra;
    logic [3:0] dina;
    logic       web;
    logic [1:0] addrb;
    logic [3:0] dinb;
    logic [3:0] doutb;
    logic [2:0] level;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         first_ov_cyc = -1;
    logic       toggle_en = 1'b0;
    logic [3:0] exp_q[$];
    logic       hold_q = 1'b0;
    logic [3:0] hold_data;
    logic [3:0] mem[4];

    always #5 clk = ~clk;

    ram_fifo_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .web      (web),
        .addrb    (addrb),
        .dinb     (dinb),
        .doutb    (doutb),
        .level    (level)
    );

    // One-cycle read latency RAM
    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        doutb <= mem[addrb];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (toggle_en) begin
            #1;
            out_ready = !out_ready;
        end
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: stability, collision, ordering; then enqueue accepted pushes.
    always @(negedge clk) begin
        if (hold_q && !rst) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(hold_data));
        end
        hold_q    = out_valid && !out_ready && !rst;
        hold_data = out_data;
        if (wea && level != 3'd0) check("no_collision", 32'(addra != addrb), 1);
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (!rst && out_valid && out_ready) begin
            check("queue_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("fifo_order", 32'(out_data), 32'(exp_q.pop_front()));
        end
        if (in_valid && in_ready) exp_q.push_back(in_data);
        if (rst) exp_q.delete();
    end

    task automatic push(input logic [3:0] d, output int acc_cyc);
        int   n = 0;
        logic acc = 1'b0;
        acc_cyc  = -1;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc     = in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("push_timeout", 32'(n), 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || level != 3'd0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t, ta;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_wea", 32'(wea), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_level", 32'(level), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_web_dinb", 32'({web, dinb}), 0);
        @(posedge clk);
        #1;

        // Basic ordering and write-to-output latency
        out_ready    = 1'b1;
        first_ov_cyc = -1;
        push(4'h1, t0);
        push(4'h2, t);
        push(4'h3, t);
        drain("drain_basic");
        check("first_out_latency", 32'(first_ov_cyc - t0), 3);

        // Fill to full with output held
        out_ready = 1'b0;
        push(4'hA, ta);
        push(4'hB, t);
        push(4'hC, t);
        push(4'hD, t);
        push(4'hE, t);
        check("e_not_stalled", 32'(t - ta), 4);
        @(negedge clk);
        check("full_level", 32'(level), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_out_valid", 32'(out_valid), 1);
        check("full_out_data", 32'(out_data), 32'hA);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 4'hF;
        @(negedge clk);
        check("full_wea", 32'(wea), 0);
        check("full_in_ready_offer", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("drain_full");

        // Continuous stream across two pointer wraps
        for (int i = 0; i < 10; i++) push(4'(i), t);
        drain("drain_wrap");

        // Back-pressure toggling every cycle
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) push(4'(i + 3), t);
        drain("drain_toggle");
        toggle_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b0;

        // Reset with level 3 and a read in flight
        push(4'h7, t);
        push(4'h8, t);
        push(4'h9, t);
        push(4'hA, t);
        push(4'hB, t);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("pre_rst_level", 32'(level), 3);
        check("pre_rst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_level", 32'(level), 0);
        check("post_rst_out_valid", 32'(out_valid), 0);
        check("post_rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(negedge clk);
        check("stale_read_ignored", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(4'h5, t);
        push(4'h6, t);
        drain("drain_after_rst");

        // Simultaneous push and issue at level 2
        out_ready = 1'b0;
        push(4'h1, t);
        push(4'h2, t);
        push(4'h3, t);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'h4;
        @(negedge clk);
        check("dual_in_ready", 32'(in_ready), 1);
        check("dual_wea", 32'(wea), 1);
        check("dual_level_before", 32'(level), 2);
        check("dual_distinct_addr", 32'(addra != addrb), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("dual_level_after", 32'(level), 2);
        @(posedge clk);
        #1;
        drain("drain_dual");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
